// File: rtl/rvfi_ibus_responder_if.sv
// Instruction fetch bus between a core (master) and the ibus responder model (slave).
interface rvfi_ibus_responder_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata, instr_err
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata, instr_err
  );
endinterface

// File: rtl/rvfi_ibus_responder.sv
// In-order instruction-bus responder with bounded latency and free stall/data inputs.
// Optional core-side protocol monitor enabled by macro RVFI_IBUS_RESP_CHECK_EN.
module rvfi_ibus_responder #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned MinLatency     = 1,
  parameter int unsigned MaxLatency     = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  rvfi_ibus_responder_if.slave                 bus,
  input  logic                                 gnt_allow_i,
  input  logic                                 rsp_allow_i,
  input  logic [31:0]                          rsp_data_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic [31:0]                          resp_addr_o,
  output logic                                 proto_err_o
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned AgeW = $clog2(MaxLatency + 1);

  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [AgeW-1:0] MinAge  = AgeW'(MinLatency);
  localparam logic [AgeW-1:0] MaxAge  = AgeW'(MaxLatency);
  localparam logic [AgeW-1:0] OneAge  = AgeW'(1);

  logic [31:0]     addr_q  [MaxOutstanding];
  logic [AgeW-1:0] age_q   [MaxOutstanding];
  logic            valid_q [MaxOutstanding];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  logic            push, pop;
  logic            head_valid;
  logic [AgeW-1:0] head_age;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign head_valid = valid_q[rd_ptr_q];
  assign head_age   = age_q[rd_ptr_q];

  // Outputs are gated by rst_ni so they fall the moment reset asserts, not at the next edge.
  assign push = rst_ni & bus.instr_req & gnt_allow_i & (count_q < MaxCnt);
  assign pop  = rst_ni & head_valid & (head_age >= MinAge)
              & (rsp_allow_i | (head_age == MaxAge));

  assign bus.instr_gnt    = push;
  assign bus.instr_rvalid = pop;
  assign bus.instr_rdata  = pop ? rsp_data_i : '0;
  assign bus.instr_err    = 1'b0;
  assign resp_addr_o      = pop ? addr_q[rd_ptr_q] : '0;
  assign outstanding_o    = count_q;

  // A pushed entry is stored already aged one cycle, so it is eligible the cycle after grant.
  for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_entry
    logic wr_here, rd_here;
    assign wr_here = push && (wr_ptr_q == PtrW'(gi));
    assign rd_here = pop && (rd_ptr_q == PtrW'(gi));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q[gi] <= 1'b0;
        age_q[gi]   <= '0;
        addr_q[gi]  <= '0;
      end else if (wr_here) begin
        valid_q[gi] <= 1'b1;
        age_q[gi]   <= OneAge;
        addr_q[gi]  <= bus.instr_addr;
      end else if (rd_here) begin
        valid_q[gi] <= 1'b0;
        age_q[gi]   <= '0;
      end else if (valid_q[gi] && (age_q[gi] != MaxAge)) begin
        age_q[gi] <= age_q[gi] + OneAge;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef RVFI_IBUS_RESP_CHECK_EN
  logic        pend_q;
  logic [31:0] pend_addr_q;
  logic        perr_q;
  logic        viol_hold, viol_align;

  // A request left ungranted must be held stable with the same address.
  assign viol_hold  = pend_q & (~bus.instr_req | (bus.instr_addr != pend_addr_q));
  assign viol_align = bus.instr_req & bus.instr_addr[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      pend_q      <= bus.instr_req & ~push;
      pend_addr_q <= bus.instr_addr;
      if (viol_hold | viol_align) perr_q <= 1'b1;
    end
  end

  assign proto_err_o = perr_q;

`ifdef FORMAL
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!viol_hold);
      assert (!viol_align);
    end
  end
`endif
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_ibus_responder.sv
// Directed self-checking bench for rvfi_ibus_responder with default parameters (2 / 1 / 3).
module tb_rvfi_ibus_responder;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        gnt_allow_i;
  logic        rsp_allow_i;
  logic [31:0] rsp_data_i;
  logic [1:0]  outstanding_o;
  logic [31:0] resp_addr_o;
  logic        proto_err_o;

  int passed = 0;
  int total  = 0;

`ifdef RVFI_IBUS_RESP_CHECK_EN
  localparam logic [31:0] PERR_EXP = 32'd1;
`else
  localparam logic [31:0] PERR_EXP = 32'd0;
`endif

  rvfi_ibus_responder_if bus_if ();

  rvfi_ibus_responder dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .bus           (bus_if.slave),
    .gnt_allow_i   (gnt_allow_i),
    .rsp_allow_i   (rsp_allow_i),
    .rsp_data_i    (rsp_data_i),
    .outstanding_o (outstanding_o),
    .resp_addr_o   (resp_addr_o),
    .proto_err_o   (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with an active request
    rst_ni = 1'b0;
    bus_if.instr_req  = 1'b1;
    bus_if.instr_addr = 32'h0;
    gnt_allow_i = 1'b1;
    rsp_allow_i = 1'b1;
    rsp_data_i  = 32'hDEADBEEF;
    #1;
    chk("rst_gnt_async", 32'(bus_if.instr_gnt), 32'd0);
    repeat (3) tick();
    #1;
    chk("rst_gnt",       32'(bus_if.instr_gnt),    32'd0);
    chk("rst_rvalid",    32'(bus_if.instr_rvalid), 32'd0);
    chk("rst_outst",     32'(outstanding_o),       32'd0);
    chk("rst_rdata",     bus_if.instr_rdata,       32'd0);
    chk("rst_resp_addr", resp_addr_o,              32'd0);
    chk("rst_perr",      32'(proto_err_o),         32'd0);
    chk("rst_err",       32'(bus_if.instr_err),    32'd0);
    bus_if.instr_req = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();

    // Single fetch
    bus_if.instr_req = 1'b1; bus_if.instr_addr = 32'h80; rsp_data_i = 32'h13;
    #1;
    chk("sf_gnt",    32'(bus_if.instr_gnt),    32'd1);
    chk("sf_rv0",    32'(bus_if.instr_rvalid), 32'd0);
    chk("sf_outst0", 32'(outstanding_o),       32'd0);
    tick();
    bus_if.instr_req = 1'b0;
    #1;
    chk("sf_rv1",    32'(bus_if.instr_rvalid), 32'd1);
    chk("sf_rdata",  bus_if.instr_rdata,       32'h13);
    chk("sf_raddr",  resp_addr_o,              32'h80);
    chk("sf_outst1", 32'(outstanding_o),       32'd1);
    tick();
    #1;
    chk("sf_rv2",    32'(bus_if.instr_rvalid), 32'd0);
    chk("sf_outst2", 32'(outstanding_o),       32'd0);
    chk("sf_rdata2", bus_if.instr_rdata,       32'd0);

    // Fill to capacity with responses withheld, then forced out at age 3
    rsp_allow_i = 1'b0; rsp_data_i = 32'hAAAA0000;
    bus_if.instr_req = 1'b1; bus_if.instr_addr = 32'h0;
    #1;
    chk("full_gnt0", 32'(bus_if.instr_gnt), 32'd1);
    tick();
    bus_if.instr_addr = 32'h4;
    #1;
    chk("full_gnt1",  32'(bus_if.instr_gnt),    32'd1);
    chk("full_rv_f1", 32'(bus_if.instr_rvalid), 32'd0);
    chk("full_out1",  32'(outstanding_o),       32'd1);
    tick();
    bus_if.instr_addr = 32'h8;
    #1;
    chk("full_gnt2",  32'(bus_if.instr_gnt),    32'd0);
    chk("full_out2",  32'(outstanding_o),       32'd2);
    chk("full_rv_f2", 32'(bus_if.instr_rvalid), 32'd0);
    tick();
    #1;
    chk("full_rv_f3",  32'(bus_if.instr_rvalid), 32'd1);
    chk("full_addr_a", resp_addr_o,              32'h0);
    chk("full_rdata",  bus_if.instr_rdata,       32'hAAAA0000);
    chk("full_nobyp",  32'(bus_if.instr_gnt),    32'd0);
    tick();
    // Head forced out while a new request is granted in the same cycle
    #1;
    chk("sim_rv",     32'(bus_if.instr_rvalid), 32'd1);
    chk("sim_addr_b", resp_addr_o,              32'h4);
    chk("sim_gnt",    32'(bus_if.instr_gnt),    32'd1);
    chk("sim_out",    32'(outstanding_o),       32'd1);
    tick();
    bus_if.instr_req = 1'b0; rsp_allow_i = 1'b1;
    #1;
    chk("sim_out2",   32'(outstanding_o),       32'd1);
    chk("sim_rv2",    32'(bus_if.instr_rvalid), 32'd1);
    chk("sim_addr_c", resp_addr_o,              32'h8);
    tick();
    #1;
    chk("empty_rv",  32'(bus_if.instr_rvalid), 32'd0);
    chk("empty_out", 32'(outstanding_o),       32'd0);
    chk("empty_ra",  resp_addr_o,              32'd0);

    // Ungranted request whose address changes
    bus_if.instr_req = 1'b1; bus_if.instr_addr = 32'h10; gnt_allow_i = 1'b0;
    #1;
    chk("pc_gnt", 32'(bus_if.instr_gnt), 32'd0);
    tick();
    bus_if.instr_addr = 32'h14;
    #1;
    chk("pc_perr0", 32'(proto_err_o), 32'd0);
    tick();
    bus_if.instr_req = 1'b0; gnt_allow_i = 1'b1;
    #1;
    chk("pc_perr1", 32'(proto_err_o), PERR_EXP);
    tick();
    #1;
    chk("pc_perr_sticky", 32'(proto_err_o), PERR_EXP);

    // Asynchronous reset with two transactions in flight
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    rsp_allow_i = 1'b0;
    bus_if.instr_req = 1'b1; bus_if.instr_addr = 32'h20;
    tick();
    bus_if.instr_addr = 32'h24;
    #1;
    chk("ar_gnt1", 32'(bus_if.instr_gnt), 32'd1);
    tick();
    rsp_allow_i = 1'b1;
    #1;
    chk("ar_out2",   32'(outstanding_o),       32'd2);
    chk("ar_rv_pre", 32'(bus_if.instr_rvalid), 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("ar_rv",    32'(bus_if.instr_rvalid), 32'd0);
    chk("ar_gnt",   32'(bus_if.instr_gnt),    32'd0);
    chk("ar_out",   32'(outstanding_o),       32'd0);
    chk("ar_rdata", bus_if.instr_rdata,       32'd0);
    chk("ar_perr",  32'(proto_err_o),         32'd0);
    bus_if.instr_req = 1'b0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ar_stale%0d", i), 32'(bus_if.instr_rvalid), 32'd0);
      tick();
    end

    // Still functional after the mid-flight reset
    bus_if.instr_req = 1'b1; bus_if.instr_addr = 32'h40; rsp_data_i = 32'h00100073;
    #1;
    chk("post_gnt", 32'(bus_if.instr_gnt), 32'd1);
    tick();
    bus_if.instr_req = 1'b0;
    #1;
    chk("post_rv",    32'(bus_if.instr_rvalid), 32'd1);
    chk("post_raddr", resp_addr_o,              32'h40);
    chk("post_rdata", bus_if.instr_rdata,       32'h00100073);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
